// File: rtl/rv32im_alu.sv
// Registered RV32IM execute-stage ALU: base integer ops plus the M extension.
// Everything is computed combinationally in one cycle and captured in a single output register.
module rv32im_alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [4:0]       SELECT,
  output logic [WIDTH-1:0] RESULT
);

  localparam int W2 = 2 * WIDTH;

  logic [4:0]       sh;
  logic             mul_a_signed;
  logic             mul_b_signed;
  logic [W2-1:0]    mul_a;
  logic [W2-1:0]    mul_b;
  logic [W2-1:0]    prod;

  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;

  assign sh = DATA2[4:0];

  // One shared 2W-bit multiplier; signedness is folded into the operand extension,
  // so the low half of the wrapped product is the correct two's-complement result.
  assign mul_a_signed = (SELECT[2:0] == 3'b001) || (SELECT[2:0] == 3'b010);
  assign mul_b_signed = (SELECT[2:0] == 3'b001);
  assign mul_a        = {{WIDTH{mul_a_signed & DATA1[WIDTH-1]}}, DATA1};
  assign mul_b        = {{WIDTH{mul_b_signed & DATA2[WIDTH-1]}}, DATA2};
  assign prod         = mul_a * mul_b;

  // Signed divide works on magnitudes; the most-negative dividend stays correct as an unsigned magnitude.
  assign div_signed = ~SELECT[0];
  assign a_neg      = div_signed & DATA1[WIDTH-1];
  assign b_neg      = div_signed & DATA2[WIDTH-1];
  assign a_mag      = a_neg ? -DATA1 : DATA1;
  assign b_mag      = b_neg ? -DATA2 : DATA2;
  assign div_zero   = (DATA2 == '0);
  assign b_safe     = div_zero ? WIDTH'(1) : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot       = div_zero ? '1 : ((a_neg ^ b_neg) ? -q_mag : q_mag);
  assign rem        = div_zero ? DATA1 : (a_neg ? -r_mag : r_mag);

  always_comb begin
    result_d = '0;
    case (SELECT)
      5'b00000: result_d = DATA1 + DATA2;
      5'b10000: result_d = DATA1 - DATA2;
      5'b00001: result_d = DATA1 << sh;
      5'b00010: result_d = {{(WIDTH-1){1'b0}}, $signed(DATA1) < $signed(DATA2)};
      5'b00011: result_d = {{(WIDTH-1){1'b0}}, DATA1 < DATA2};
      5'b00100: result_d = DATA1 ^ DATA2;
      5'b00101: result_d = DATA1 >> sh;
      5'b10101: result_d = $unsigned($signed(DATA1) >>> sh);
      5'b00110: result_d = DATA1 | DATA2;
      5'b00111: result_d = DATA1 & DATA2;
      5'b01000: result_d = prod[WIDTH-1:0];
      5'b01001, 5'b01010, 5'b01011: result_d = prod[W2-1:WIDTH];
      5'b01100, 5'b01101: result_d = quot;
      5'b01110, 5'b01111: result_d = rem;
      default:  result_d = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign RESULT = result_q;

endmodule

// File: tb/tb_rv32im_alu.sv
// Bench for rv32im_alu: directed literal cases, then randomized ops against a plain-arithmetic model.
module tb_rv32im_alu;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b10000, SLL = 5'b00001, SLT = 5'b00010;
  localparam logic [4:0] SLTU = 5'b00011, XOR = 5'b00100, SRL = 5'b00101, SRA = 5'b10101;
  localparam logic [4:0] OR_ = 5'b00110, AND_ = 5'b00111, MUL = 5'b01000, MULH = 5'b01001;
  localparam logic [4:0] MULHSU = 5'b01010, MULHU = 5'b01011, DIV = 5'b01100, DIVU = 5'b01101;
  localparam logic [4:0] REM = 5'b01110, REMU = 5'b01111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic [4:0]  sel = '0;
  logic [31:0] result;

  logic        lit_valid = 1'b0;
  logic [31:0] lit_exp = '0;
  string       lit_name = "";

  int assertions = 0;
  int failures   = 0;

  rv32im_alu #(.WIDTH(32)) dut (
    .CLK(clk), .RESET(rst_n), .DATA1(data1), .DATA2(data2), .SELECT(sel), .RESULT(result)
  );

  always #5 clk = ~clk;

  // Reference: what RESULT must become at an edge with these inputs, using native integer arithmetic.
  function automatic logic [31:0] model(input logic r, input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] s);
    int              sa, sb;
    longint          ps;
    longint unsigned pu;
    logic [63:0]     p;
    int unsigned     shamt;
    sa    = int'(a);
    sb    = int'(b);
    shamt = int'(b % 32);
    if (!r) return 32'h0;
    case (s)
      ADD:  return a + b;
      SUB:  return a - b;
      SLL:  return a << shamt;
      SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      SLTU: return (a < b) ? 32'd1 : 32'd0;
      XOR:  return a ^ b;
      SRL:  return a >> shamt;
      SRA:  return 32'(sa >>> shamt);
      OR_:  return a | b;
      AND_: return a & b;
      MUL:  begin pu = longint'(a) * longint'(b); p = pu; return p[31:0]; end
      MULH: begin ps = longint'(sa) * longint'(sb); p = ps; return p[63:32]; end
      MULHSU: begin ps = longint'(sa) * longint'({32'h0, b}); p = ps; return p[63:32]; end
      MULHU: begin pu = longint'({32'h0, a}) * longint'({32'h0, b}); p = pu; return p[63:32]; end
      DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      REMU: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Compare process: capture the model at each edge, check the registered result just after it.
  always @(posedge clk) begin
    logic [31:0] exp_m;
    logic        lv;
    logic [31:0] le;
    string       ln;
    exp_m = model(rst_n, data1, data2, sel);
    lv    = lit_valid;
    le    = lit_exp;
    ln    = lit_name;
    #1;
    assertions++;
    if (result !== exp_m) begin
      failures++;
      $display("FAIL model sel=%05b a=%08h b=%08h rst=%0d: got %08h want %08h",
               sel, data1, data2, rst_n, result, exp_m);
    end
    if (lv) begin
      assertions++;
      if (result !== le) begin
        failures++;
        $display("FAIL %s: got %08h want %08h", ln, result, le);
      end else begin
        $display("ok   %s: %08h", ln, result);
      end
    end
  end

  task automatic op(input logic r, input logic [4:0] s, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input string name);
    @(negedge clk);
    rst_n     = r;
    sel       = s;
    data1     = a;
    data2     = b;
    lit_valid = 1'b1;
    lit_exp   = exp;
    lit_name  = name;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'($urandom_range(0, 40));
      4: return 32'(-$urandom_range(1, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    op(1'b0, ADD, 5, 9, 32'd0, "reset");
    op(1'b1, ADD, 5, 9, 32'd14, "add_after_reset");
    op(1'b1, SLL, 3, 3, 32'd24, "sll");
    op(1'b1, SLT, 3, 3, 32'd0, "slt_eq");
    op(1'b1, SLTU, 3, 3, 32'd0, "sltu_eq");
    op(1'b1, XOR, 3, 1, 32'd2, "xor");
    op(1'b1, SRL, 3, 1, 32'd1, "srl");
    op(1'b1, OR_, 3, 1, 32'd3, "or");
    op(1'b1, AND_, 3, 1, 32'd1, "and");
    op(1'b1, SUB, 3, 5, 32'hFFFF_FFFE, "sub_neg");
    op(1'b1, SRA, 32'h8000_0000, 4, 32'hF800_0000, "sra");
    op(1'b1, SLT, 32'hFFFF_FFFF, 1, 32'd1, "slt_neg");
    op(1'b1, SLTU, 32'hFFFF_FFFF, 1, 32'd0, "sltu_big");
    op(1'b1, MUL, 5, 2, 32'd10, "mul");
    op(1'b1, MULH, 5, 1, 32'd0, "mulh_small");
    op(1'b1, MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, "mulh_m1");
    op(1'b1, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    op(1'b1, MULHSU, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, "mulhsu");
    op(1'b1, DIV, 7, 2, 32'd3, "div");
    op(1'b1, DIVU, 5, 2, 32'd2, "divu");
    op(1'b1, REM, 5, 2, 32'd1, "rem");
    op(1'b1, REMU, 5, 2, 32'd1, "remu");
    op(1'b1, DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, "div_neg");
    op(1'b1, REM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, "rem_neg");
    op(1'b1, DIV, 5, 0, 32'hFFFF_FFFF, "div_by_zero");
    op(1'b1, REMU, 5, 0, 32'd5, "remu_by_zero");
    op(1'b1, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_overflow");
    op(1'b1, REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_overflow");
    op(1'b1, 5'b11111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, "undefined_sel");
    op(1'b1, SLL, 1, 32, 32'd1, "sll_by_32");
    op(1'b1, SRA, 32'hF000_0000, 32'hFFFF_FFE4, 32'hFF00_0000, "sra_high_bits");
    op(1'b0, ADD, 1, 2, 32'd0, "reset_midstream");
    op(1'b1, ADD, 1, 2, 32'd3, "resume");
    op(1'b1, SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, "sub_wrap");

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      lit_valid = 1'b0;
      rst_n     = ($urandom_range(0, 49) != 0);
      sel       = ($urandom_range(0, 1) == 0) ? 5'({$urandom_range(0, 1), 1'b1, 3'($urandom_range(0, 7))})
                                              : 5'($urandom_range(0, 31));
      data1     = rand_operand();
      data2     = rand_operand();
    end

    @(negedge clk);
    lit_valid = 1'b0;
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/rv32im_alu.md
Name: rv32im_alu

Overview:
- Registered 32-bit integer ALU for the RV32IM pipelined core's execute stage.
- Covers all RV32I register/immediate arithmetic, logic, shift and compare ops, plus the full M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), chosen by a 5-bit SELECT code from the decoder.
- The result is registered on the rising clock edge (one-cycle latency) and feeds the EX/MEM pipeline register path.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported. Shift amount is always taken from DATA2[4:0].

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-low reset; sampled on CLK rising edge.
- DATA1  input  32  operand A (rs1).
- DATA2  input  32  operand B (rs2 or immediate).
- SELECT  input  5  operation code; SELECT[4] is funct7[5] for base ops, SELECT[3] selects the M extension, SELECT[2:0] is funct3.
- RESULT  output  32  registered result.

Behaviour:
- Reset: if RESET==0 at a rising CLK edge, RESULT <= 0. Reset wins over any operation presented in the same cycle.
- Normal operation: at each rising edge with RESET==1, RESULT <= f(DATA1, DATA2, SELECT) using the inputs sampled at that edge.
  - Latency is exactly 1 cycle.
  - No handshake and no stall; a new operation may be issued every cycle.
  - RESULT holds its value between edges.
- SELECT encoding (operands treated as signed only where noted; sh = DATA2[4:0]):
  - 00000 ADD: DATA1+DATA2, modulo 2^32.
  - 10000 SUB: DATA1-DATA2, modulo 2^32.
  - 00001 SLL: DATA1 << sh.
  - 00010 SLT: 1 if signed DATA1 < signed DATA2, else 0.
  - 00011 SLTU: 1 if unsigned DATA1 < unsigned DATA2, else 0.
  - 00100 XOR: bitwise XOR.
  - 00101 SRL: logical shift right of DATA1 by sh.
  - 10101 SRA: arithmetic shift right of DATA1 by sh (sign-filled).
  - 00110 OR: bitwise OR.
  - 00111 AND: bitwise AND.
  - 01000 MUL: low 32 bits of DATA1*DATA2.
  - 01001 MULH: high 32 bits of signed x signed 64-bit product.
  - 01010 MULHSU: high 32 bits of signed DATA1 x unsigned DATA2.
  - 01011 MULHU: high 32 bits of unsigned x unsigned product.
  - 01100 DIV: signed quotient, truncated toward zero.
  - 01101 DIVU: unsigned quotient.
  - 01110 REM: signed remainder; sign follows the dividend.
  - 01111 REMU: unsigned remainder.
  - Any other code: result 0.
- Boundary cases, per the RISC-V spec, with no trap and no extra flag:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give DATA1.
  - Signed overflow (DATA1=0x80000000, DATA2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Shift amount: bits DATA2[31:5] are ignored, so a shift by 32 behaves as a shift by 0.
- The datapath is fully combinational with a single output register. Multiply and divide complete in one cycle; no multi-cycle iteration.
- X or undefined SELECT must never propagate a latch; the output register is the only state.

Test Plan:
- Reset: drive RESET=0 with DATA1=5, DATA2=9, SELECT=00000 for one edge -> RESULT=0. Release RESET -> after the next edge RESULT=14.
- Base ops back-to-back, one per cycle, each result checked one cycle later:
  - ADD 5+9 -> 14; SLL 3,3 -> 24; SLT 3,3 -> 0; SLTU 3,3 -> 0.
  - XOR 3,1 -> 2; SRL 3,1 -> 1; OR 3,1 -> 3; AND 3,1 -> 1.
  - SUB 3,5 -> 0xFFFFFFFE; SRA 0x80000000,4 -> 0xF8000000.
  - SLT 0xFFFFFFFF,1 -> 1; SLTU 0xFFFFFFFF,1 -> 0.
- Multiply ops:
  - MUL 5,2 -> 10; MULH 5,1 -> 0.
  - MULH 0xFFFFFFFF,0xFFFFFFFF -> 0.
  - MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF,2 -> 0xFFFFFFFF.
- Divide ops:
  - DIV 7,2 -> 3; DIVU 5,2 -> 2; REM 5,2 -> 1; REMU 5,2 -> 1.
  - DIV -7,2 -> 0xFFFFFFFD (-3); REM -7,2 -> 0xFFFFFFFF (-1).
- Division corner cases:
  - DIV 5,0 -> 0xFFFFFFFF; REMU 5,0 -> 5.
  - DIV 0x80000000,0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Undefined SELECT=11111 -> 0. Assert RESET=0 in the middle of a stream -> RESULT=0 at that edge, and the stream resumes correctly after release.
